// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, port indices and the address legality check
// used by the data-memory arbiter and its round-robin core.
package dmem_arb_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // An access is legal when it is word aligned and its word index falls
  // inside the memory.
  function automatic u1 addr_legal(input u32 addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (32'(addr[31:2]) < depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk    system clock
//   reset  synchronous active-high; suppresses grants and points rr_ptr at port 0
//   req    request vector, bit index = port
//   gnt    one-hot (or zero) grant vector, combinational from req and rr_ptr
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Port that wins when both request: 0 = CPU, 1 = debug.
  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req[PORT_CPU] && (!req[PORT_DBG] || (rr_ptr == 1'b0))) begin
        gnt[PORT_CPU] = 1'b1;
      end else if (req[PORT_DBG]) begin
        gnt[PORT_DBG] = 1'b1;
      end
    end
  end

  // After any grant, priority passes to the other port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (gnt[PORT_CPU]) begin
      rr_ptr <= 1'b1;
    end else if (gnt[PORT_DBG]) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory (sync write, combinational read)
// between the CPU port (p0) and the debug/loader port (p1).
//   clk, reset            clock and synchronous active-high reset
//   pN_req/we/addr/wdata  request from port N, held until pN_gnt
//   pN_gnt                access accepted this cycle (combinational)
//   pN_rvalid/err/rdata   registered response one cycle after the grant
//   mem_we/addr/wdata     memory write/address port
//   mem_rdata             combinational read data from memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int          DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_err,
  output logic              p1_err,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              sel_we;
  u32                sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  logic [1:0]             vld_p1;
  logic [1:0]             err_p1;
  logic [1:0][DATA_W-1:0] rdata_p1;

  assign req = {p1_req, p0_req};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign p0_gnt = gnt[PORT_CPU];
  assign p1_gnt = gnt[PORT_DBG];

  // Stage p0: route the granted port onto the memory bus; idle bus is all zero.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[PORT_CPU]) begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end else if (gnt[PORT_DBG]) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  assign sel_legal = addr_legal(sel_addr, DEPTH);
  // Illegal accesses still take the slot but must never reach the array.
  assign mem_we    = sel_we & sel_legal;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  // Stage p1: response registers, loaded at the grant edge. A non-granted
  // port keeps its last rdata so a consumer can look at it late.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= '0;
      err_p1   <= '0;
      rdata_p1 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        vld_p1[i] <= gnt[i];
        err_p1[i] <= gnt[i] & ~sel_legal;
        if (gnt[i]) begin
          rdata_p1[i] <= (sel_legal && !sel_we) ? mem_rdata : '0;
        end
      end
    end
  end

  // A response is dropped if reset arrives in the cycle it is presented.
  assign p0_rvalid = vld_p1[PORT_CPU] & ~reset;
  assign p1_rvalid = vld_p1[PORT_DBG] & ~reset;
  assign p0_err    = err_p1[PORT_CPU] & ~reset;
  assign p1_err    = err_p1[PORT_DBG] & ~reset;
  assign p0_rdata  = rdata_p1[PORT_CPU];
  assign p1_rdata  = rdata_p1[PORT_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  // Requester state driven onto the DUT.
  logic        act [2];
  logic        wr  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];

  assign p0_req   = act[0];
  assign p0_we    = wr[0];
  assign p0_addr  = ad[0];
  assign p0_wdata = wd[0];
  assign p1_req   = act[1];
  assign p1_we    = wr[1];
  assign p1_addr  = ad[1];
  assign p1_wdata = wd[1];

  // Memory attached to the DUT.
  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .p0_err    (p0_err),
    .p1_err    (p1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, priority owner, expected responses.
  logic [31:0] ref_mem [DEPTH];
  int          prio;
  logic        exp_vld [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  task automatic step();
    int win;
    bit lg;
    win = -1;
    @(negedge clk);
    if (!reset) begin
      if (act[0] && act[1]) win = prio;
      else if (act[0])      win = 0;
      else if (act[1])      win = 1;
    end
    lg = (win >= 0) ? is_legal(ad[win]) : 1'b0;
    chk("p0_gnt", p0_gnt, win == 0);
    chk("p1_gnt", p1_gnt, win == 1);
    chk("mem_we", mem_we, (win >= 0) && lg && wr[win]);
    chk("mem_addr", mem_addr, (win >= 0) ? ad[win] : 32'h0);
    chk("mem_wdata", mem_wdata, (win >= 0) ? wd[win] : 32'h0);
    chk("p0_rvalid", p0_rvalid, exp_vld[0] && !reset);
    chk("p1_rvalid", p1_rvalid, exp_vld[1] && !reset);
    chk("p0_err", p0_err, exp_err[0] && !reset);
    chk("p1_err", p1_err, exp_err[1] && !reset);
    chk("p0_rdata", p0_rdata, exp_rd[0]);
    chk("p1_rdata", p1_rdata, exp_rd[1]);
    for (int i = 0; i < 2; i++) begin
      exp_vld[i] = 1'b0;
      exp_err[i] = 1'b0;
      if (reset) exp_rd[i] = 32'h0;
    end
    if (reset) begin
      prio = 0;
    end else if (win >= 0) begin
      exp_vld[win] = 1'b1;
      exp_err[win] = !lg;
      exp_rd[win]  = (lg && !wr[win]) ? ref_mem[ad[win] / 4] : 32'h0;
      if (lg && wr[win]) ref_mem[ad[win] / 4] = wd[win];
      prio = 1 - win;
    end
    @(posedge clk);
    #1;
    if (win >= 0) act[win] = 1'b0;
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    act[p] = 1'b1;
    wr[p]  = w;
    ad[p]  = a;
    wd[p]  = d;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)       return 32'($urandom_range(0, 7)) * 4;
    else if (r < 7)  return 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (r == 7) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'($urandom_range(DEPTH, DEPTH + 15)) * 4;
    else             return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; wr[i] = 1'b0; ad[i] = 32'h0; wd[i] = 32'h0;
      exp_vld[i] = 1'b0; exp_err[i] = 1'b0; exp_rd[i] = 32'h0;
    end
    prio  = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    repeat (2) step();

    // Write from CPU, then read the same word from debug.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
    step();
    issue(1, 1'b0, 32'h10, 32'h0);
    step();
    chk("wr_rd_p1_rvalid", p1_rvalid, 1'b1);
    chk("wr_rd_p1_rdata", p1_rdata, 32'hDEADBEEF);
    step();

    // Both ports read continuously.
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 2; p++) if (!act[p]) issue(p, 1'b0, 32'h10, 32'h0);
      step();
    end
    act[0] = 1'b0; act[1] = 1'b0;
    step();

    // Misaligned and out-of-range accesses.
    issue(1, 1'b1, 32'h102, 32'h12345678);
    step();
    chk("misalign_err", p1_err, 1'b1);
    issue(1, 1'b1, 32'h100, 32'h87654321);
    step();
    chk("oor_err", p1_err, 1'b1);
    chk("oor_rdata", p1_rdata, 32'h0);
    issue(1, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Reset cuts off a write presented in the reset cycle.
    issue(0, 1'b1, 32'h4, 32'hAAAA5555);
    step();
    reset = 1'b1;
    issue(0, 1'b1, 32'h4, 32'h1);
    step();
    reset  = 1'b0;
    act[0] = 1'b0;
    issue(0, 1'b0, 32'h4, 32'h0);
    issue(1, 1'b0, 32'h4, 32'h0);
    step();
    chk("rst_ptr_p0_rvalid", p0_rvalid, 1'b1);
    chk("rst_readback", p0_rdata, 32'hAAAA5555);
    step();
    step();

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ($urandom_range(0, 2) != 0))
          issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      reset = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
